// File: rtl/mmu_pkg.sv
// Shared state enum, latency and saturating-add helpers for the mmu_array systolic unit.
// The saturating add is used only when MMU_SAT_EN is defined.
package mmu_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, SWAP} wfsm_e;

   localparam int SAT_MAX_W = 64;
   localparam int SAT_SUM_W = SAT_MAX_W + 1;

   function automatic int latency(input int rows, input int cols);
      return rows + cols;
   endfunction

   // Clamps x+y to the signed range of a w-bit result (w <= SAT_MAX_W).
   function automatic logic signed [SAT_MAX_W-1:0] sat_add(
      input logic signed [SAT_MAX_W-1:0] x,
      input logic signed [SAT_MAX_W-1:0] y,
      input int                          w
   );
      logic signed [SAT_SUM_W-1:0] s;
      logic signed [SAT_SUM_W-1:0] one;
      logic signed [SAT_SUM_W-1:0] hi;
      logic signed [SAT_SUM_W-1:0] lo;
      one    = '0;
      one[0] = 1'b1;
      s      = SAT_SUM_W'(x) + SAT_SUM_W'(y);
      hi     = (one <<< (w - 1)) - one;
      lo     = -(one <<< (w - 1));
      if (s > hi) return hi[SAT_MAX_W-1:0];
      if (s < lo) return lo[SAT_MAX_W-1:0];
      return s[SAT_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/mmu_array_if.sv
// Weight, activation and result channels of mmu_array; master = producer side, slave = the array.
interface mmu_array_if #(
   parameter int ROWS   = 8,
   parameter int COLS   = 8,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16
);
   logic                     w_valid;
   logic                     w_ready;
   logic [COLS*DATA_W-1:0]   w_data;
   logic                     a_valid;
   logic                     a_ready;
   logic [ROWS*DATA_W-1:0]   a_data;
   logic                     r_valid;
   logic [COLS*ACC_W-1:0]    r_data;
   logic                     busy;

   modport master (
      output w_valid, w_data, a_valid, a_data,
      input  w_ready, a_ready, r_valid, r_data, busy
   );

   modport slave (
      input  w_valid, w_data, a_valid, a_data,
      output w_ready, a_ready, r_valid, r_data, busy
   );
endinterface

// File: rtl/mmu_pe.sv
// One systolic PE: shadow/active weight pair, MAC into a registered psum, registered activation pass-through.
// One cycle per hop; MMU_SAT_EN selects a saturating add instead of wrap.
module mmu_pe
   import mmu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic signed [DATA_W-1:0] act_i,
   input  logic signed [ACC_W-1:0]  psum_i,
   input  logic                     wt_we_i,
   input  logic signed [DATA_W-1:0] wt_i,
   input  logic                     swap_i,
   output logic signed [DATA_W-1:0] act_o,
   output logic signed [ACC_W-1:0]  psum_o
);
   localparam int PROD_W = 2 * DATA_W;

   logic signed [DATA_W-1:0] wt_act_q;
   logic signed [DATA_W-1:0] wt_shd_q;
   logic signed [DATA_W-1:0] act_q;
   logic signed [ACC_W-1:0]  psum_q;
   logic signed [ACC_W-1:0]  psum_d;
   logic signed [PROD_W-1:0] prod;

   assign prod = PROD_W'(act_i) * PROD_W'(wt_act_q);

`ifdef MMU_SAT_EN
   if (ACC_W > SAT_MAX_W) begin : g_chk_sat
      $error("mmu_pe: ACC_W too wide for the saturating adder");
   end
   assign psum_d = ACC_W'(sat_add(SAT_MAX_W'(psum_i), SAT_MAX_W'(prod), ACC_W));
`else
   assign psum_d = psum_i + ACC_W'(prod);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wt_act_q <= '0;
         wt_shd_q <= '0;
         act_q    <= '0;
         psum_q   <= '0;
      end else begin
         if (wt_we_i) wt_shd_q <= wt_i;
         if (swap_i)  wt_act_q <= wt_shd_q;
         act_q  <= act_i;
         psum_q <= psum_d;
      end
   end

   assign act_o  = act_q;
   assign psum_o = psum_q;
endmodule

// File: rtl/mmu_array.sv
// ROWSxCOLS systolic matmul with internal skew/deskew and double-buffered weights; result at accept+ROWS+COLS.
// Activations stall only before the first load and while a new weight set drains/swaps; MMU_SAT_EN selects saturation.
module mmu_array
   import mmu_pkg::*;
#(
   parameter int ROWS   = 8,
   parameter int COLS   = 8,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   mmu_array_if.slave  bus
);
   localparam int LAT   = latency(ROWS, COLS);
   // Holds LAT+1: a vector stays counted through the cycle its result is on the output.
   localparam int CNT_W = $clog2(ROWS + COLS + 2);
   localparam int RC_W  = $clog2(ROWS + 1);

   if (ACC_W < 2 * DATA_W) begin : g_chk_acc
      $error("mmu_array: ACC_W must be at least 2*DATA_W");
   end

   wfsm_e             state_q, state_d;
   logic [RC_W-1:0]   row_q, row_d;
   logic              wts_loaded_q, wts_loaded_d;
   logic              swap;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              w_acc, a_acc;
   logic [LAT-1:0]    vld_q;
   logic              r_valid_q;
   logic [COLS*ACC_W-1:0] r_data_q;

   logic signed [DATA_W-1:0] in_q    [ROWS];
   logic signed [DATA_W-1:0] row_act [ROWS];
   logic signed [DATA_W-1:0] act_w   [ROWS][COLS];
   logic signed [ACC_W-1:0]  psum_w  [ROWS][COLS];
   logic signed [ACC_W-1:0]  col_out [COLS];

   assign bus.w_ready = (state_q == IDLE) || (state_q == LOAD);
   assign bus.a_ready = wts_loaded_q && ((state_q == IDLE) || (state_q == LOAD));
   assign w_acc       = bus.w_valid && bus.w_ready;
   assign a_acc       = bus.a_valid && bus.a_ready;
   assign bus.busy    = (cnt_q != '0) || (state_q != IDLE);
   assign bus.r_valid = r_valid_q;
   assign bus.r_data  = r_data_q;

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      wts_loaded_d = wts_loaded_q;
      swap         = 1'b0;
      case (state_q)
         IDLE, LOAD: begin
            if (w_acc) begin
               if (row_q == RC_W'(ROWS - 1)) begin
                  row_d   = '0;
                  state_d = DRAIN;
               end else begin
                  row_d   = row_q + RC_W'(1);
                  state_d = LOAD;
               end
            end
         end
         DRAIN:   if (cnt_q == '0) state_d = SWAP;
         SWAP: begin
            swap         = 1'b1;
            wts_loaded_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cnt_d = cnt_q + CNT_W'(a_acc) - CNT_W'(r_valid_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         row_q        <= '0;
         wts_loaded_q <= 1'b0;
         cnt_q        <= '0;
         vld_q        <= '0;
         r_valid_q    <= 1'b0;
         r_data_q     <= '0;
         for (int i = 0; i < ROWS; i++) in_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         wts_loaded_q <= wts_loaded_d;
         cnt_q        <= cnt_d;
         vld_q        <= {vld_q[LAT-2:0], a_acc};
         r_valid_q    <= vld_q[LAT-1];
         for (int j = 0; j < COLS; j++) r_data_q[j*ACC_W +: ACC_W] <= col_out[j];
         for (int i = 0; i < ROWS; i++)
            in_q[i] <= a_acc ? bus.a_data[i*DATA_W +: DATA_W] : '0;
      end
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_skew
      if (i == 0) begin : g_d0
         assign row_act[i] = in_q[i];
      end else begin : g_dn
         logic signed [DATA_W-1:0] sr_q [i];
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int k = 0; k < i; k++) sr_q[k] <= '0;
            end else begin
               sr_q[0] <= in_q[i];
               for (int k = 1; k < i; k++) sr_q[k] <= sr_q[k-1];
            end
         end
         assign row_act[i] = sr_q[i-1];
      end
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_row
      for (genvar j = 0; j < COLS; j++) begin : g_col
         logic signed [DATA_W-1:0] a_in;
         logic signed [ACC_W-1:0]  p_in;
         if (j == 0) begin : g_a0
            assign a_in = row_act[i];
         end else begin : g_an
            assign a_in = act_w[i][j-1];
         end
         if (i == 0) begin : g_p0
            assign p_in = '0;
         end else begin : g_pn
            assign p_in = psum_w[i-1][j];
         end
         mmu_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
            .clk     (clk),
            .reset_n (reset_n),
            .act_i   (a_in),
            .psum_i  (p_in),
            .wt_we_i (w_acc && (row_q == RC_W'(i))),
            .wt_i    (bus.w_data[j*DATA_W +: DATA_W]),
            .swap_i  (swap),
            .act_o   (act_w[i][j]),
            .psum_o  (psum_w[i][j])
         );
      end
   end

   for (genvar j = 0; j < COLS; j++) begin : g_dsk
      localparam int D = COLS - 1 - j;
      if (D == 0) begin : g_d0
         assign col_out[j] = psum_w[ROWS-1][j];
      end else begin : g_dn
         logic signed [ACC_W-1:0] dq [D];
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int k = 0; k < D; k++) dq[k] <= '0;
            end else begin
               dq[0] <= psum_w[ROWS-1][j];
               for (int k = 1; k < D; k++) dq[k] <= dq[k-1];
            end
         end
         assign col_out[j] = dq[D-1];
      end
   end
endmodule

// File: tb/tb_mmu_array.sv
// Scoreboard bench for mmu_array at ROWS=COLS=2, DATA_W=8, ACC_W=16.
module tb_mmu_array;
   localparam int R = 2, C = 2, DW = 8, AW = 16;

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   typedef struct {
      logic [15:0] r0;
      logic [15:0] r1;
      int          cyc;
   } exp_t;
   exp_t exp_q[$];

   mmu_array_if #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(AW)) bus ();
   mmu_array #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(AW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   function automatic logic [15:0] pk(input int lo, input int hi);
      logic [31:0] l, h;
      l = lo;
      h = hi;
      return {h[7:0], l[7:0]};
   endfunction

   function automatic logic [15:0] ev(input int x);
      logic [31:0] t;
      t = x;
      return t[15:0];
   endfunction

   // Monitor: every valid result must match the oldest outstanding expectation, at its cycle.
   always @(negedge clk) begin : mon
      exp_t e;
      if (bus.r_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected r_valid", {31'b0, bus.r_valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("r col0", {16'b0, bus.r_data[15:0]},  {16'b0, e.r0});
            chk("r col1", {16'b0, bus.r_data[31:16]}, {16'b0, e.r1});
            chk("r latency", cyc, e.cyc);
         end
      end
   end

   task automatic step(input logic av, input logic [15:0] ad, input logic wv, input logic [15:0] wd,
                       input logic [15:0] e0, input logic [15:0] e1);
      @(negedge clk);
      bus.a_valid = av;
      bus.a_data  = ad;
      bus.w_valid = wv;
      bus.w_data  = wd;
      if (av && bus.a_ready === 1'b1) exp_q.push_back('{e0, e1, cyc + 5});
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
   endtask

   // Drives garbage weights (and optional activations) until the FSM is back in IDLE.
   task automatic wait_swap(input logic av, input logic [15:0] ad, input string tag);
      int n = 0;
      @(negedge clk);
      while (bus.w_ready !== 1'b1 && n < 40) begin
         bus.w_valid = 1'b1;
         bus.w_data  = 16'h7F7F;
         bus.a_valid = av;
         bus.a_data  = ad;
         chk({tag, " a_ready in drain/swap"}, {31'b0, bus.a_ready}, 32'd0);
         chk({tag, " busy in drain/swap"}, {31'b0, bus.busy}, 32'd1);
         n++;
         @(negedge clk);
      end
      bus.w_valid = 1'b0;
      bus.a_valid = 1'b0;
      chk({tag, " swap done"}, {31'b0, bus.w_ready}, 32'd1);
      chk({tag, " a_ready after swap"}, {31'b0, bus.a_ready}, 32'd1);
   endtask

   task automatic load(input logic [15:0] w0, input logic [15:0] w1, input string tag);
      step(1'b0, 16'h0, 1'b1, w0, 16'h0, 16'h0);
      chk({tag, " w_ready beat0"}, {31'b0, bus.w_ready}, 32'd1);
      step(1'b0, 16'h0, 1'b1, w1, 16'h0, 16'h0);
      chk({tag, " w_ready beat1"}, {31'b0, bus.w_ready}, 32'd1);
      wait_swap(1'b0, 16'h0, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset_n     = 1'b0;
      bus.a_valid = 1'b0;
      bus.a_data  = '0;
      bus.w_valid = 1'b0;
      bus.w_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst w_ready", {31'b0, bus.w_ready}, 32'd1);
      chk("rst a_ready", {31'b0, bus.a_ready}, 32'd0);
      chk("rst r_valid", {31'b0, bus.r_valid}, 32'd0);
      chk("rst r_data",  bus.r_data, 32'd0);
      chk("rst busy",    {31'b0, bus.busy}, 32'd0);
      reset_n = 1'b1;

      repeat (3) begin
         step(1'b1, pk(1, 1), 1'b0, 16'h0, 16'h0, 16'h0);
         chk("preload a_ready", {31'b0, bus.a_ready}, 32'd0);
      end
      idle(2);

      load(pk(1, 0), pk(0, 1), "ident");
      step(1'b1, pk(3, -5), 1'b0, 16'h0, ev(3), ev(-5));
      idle(8);
      chk("ident busy after", {31'b0, bus.busy}, 32'd0);

      step(1'b1, pk(1, 2), 1'b0, 16'h0, ev(1), ev(2));
      step(1'b1, pk(3, 4), 1'b0, 16'h0, ev(3), ev(4));
      step(1'b1, pk(5, 6), 1'b0, 16'h0, ev(5), ev(6));
      idle(8);

      load(pk(1, 2), pk(3, 4), "db0");
      step(1'b1, pk(1, 1), 1'b0, 16'h0,    ev(4), ev(6));
      step(1'b1, pk(1, 1), 1'b0, 16'h0,    ev(4), ev(6));
      step(1'b1, pk(1, 1), 1'b1, pk(0, 0), ev(4), ev(6));
      step(1'b1, pk(1, 1), 1'b1, pk(0, 1), ev(4), ev(6));
      wait_swap(1'b1, pk(1, 1), "db1");
      step(1'b1, pk(1, 1), 1'b0, 16'h0, ev(0), ev(1));
      step(1'b1, pk(1, 1), 1'b0, 16'h0, ev(0), ev(1));
      idle(8);
      chk("db busy after", {31'b0, bus.busy}, 32'd0);

      load(pk(127, 127), pk(127, 127), "ov1");
      step(1'b1, pk(127, 127), 1'b0, 16'h0, ev(32258), ev(32258));
      idle(8);
      load(pk(-128, -128), pk(-128, -128), "ov2");
`ifdef MMU_SAT_EN
      step(1'b1, pk(-128, -128), 1'b0, 16'h0, ev(32767), ev(32767));
`else
      step(1'b1, pk(-128, -128), 1'b0, 16'h0, ev(-32768), ev(-32768));
`endif
      idle(8);

      step(1'b1, pk(1, 1), 1'b0, 16'h0, 16'h0, 16'h0);
      step(1'b1, pk(1, 1), 1'b0, 16'h0, 16'h0, 16'h0);
      step(1'b1, pk(1, 1), 1'b0, 16'h0, 16'h0, 16'h0);
      @(negedge clk);
      bus.a_valid = 1'b0;
      reset_n     = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst r_valid", {31'b0, bus.r_valid}, 32'd0);
      chk("midrst busy",    {31'b0, bus.busy}, 32'd0);
      chk("midrst w_ready", {31'b0, bus.w_ready}, 32'd1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (8) begin
         step(1'b1, pk(2, 2), 1'b0, 16'h0, 16'h0, 16'h0);
         chk("postrst a_ready", {31'b0, bus.a_ready}, 32'd0);
      end
      load(pk(1, 0), pk(0, 1), "reload");
      step(1'b1, pk(7, -9), 1'b0, 16'h0, ev(7), ev(-9));
      idle(8);

      chk("scoreboard drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
